led_pattern_engine: RTL

//  Parametrised LED pattern generator for N LEDs.

---
 rtl/led_pattern_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: runtime-selectable LED pattern generator for N_LEDS outputs.
// Modes: marquee, blink, true-PWM breathe, bounce. All state runs only while
// en & pll_locked; leds and step_pulse are registered.
module led_pattern_engine #(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned CLK_FREQ = 200_000_000,
  parameter int unsigned STEP_HZ  = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned RAMP_DIV = 200_000
) (
  input  logic              pll_clk,
  input  logic              rst_sync,
  input  logic              pll_locked,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic              step_pulse
);

  localparam int unsigned STEP_DIV = CLK_FREQ / STEP_HZ;
  localparam int unsigned PRE_W    = $clog2(STEP_DIV);
  localparam int unsigned RAMP_W   = $clog2(RAMP_DIV);
  localparam int unsigned POS_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    M_MARQUEE = 2'd0,
    M_BLINK   = 2'd1,
    M_BREATHE = 2'd2,
    M_BOUNCE  = 2'd3
  } mode_e;

  // dir: 0 = up (increasing pos/level), 1 = down
  mode_e               mode_q,  mode_d;
  logic [PRE_W-1:0]    pre_q,   pre_d;
  logic [RAMP_W-1:0]   ramp_q,  ramp_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [POS_W-1:0]    pos_q,   pos_d;
  logic                dir_q,   dir_d;
  logic                phase_q, phase_d;
  logic [N_LEDS-1:0]   leds_q,  leds_d;
  logic                step_pulse_q, step_pulse_d;

  logic              run_c;
  logic              step_tick_c;
  logic              mode_chg_c;
  logic [N_LEDS-1:0] pattern_c;

  assign run_c       = en & pll_locked;
  assign step_tick_c = run_c & (pre_q == PRE_LAST);
  assign mode_chg_c  = run_c & (mode_e'(mode) != mode_q);

  // LED image of the current state; registered into leds_q one cycle later
  always_comb begin
    pattern_c = '0;
    case (mode_q)
      M_MARQUEE, M_BOUNCE: pattern_c = N_LEDS'(1) << pos_q;
      M_BLINK:             pattern_c = {N_LEDS{phase_q}};
      M_BREATHE:           pattern_c = {N_LEDS{pwm_q < level_q}};
      default:             pattern_c = '0;
    endcase
  end

  // Next-state: prescaler, mode switch (wins over a coincident tick), pattern advance
  always_comb begin
    mode_d       = mode_q;
    pre_d        = pre_q;
    ramp_d       = ramp_q;
    pwm_d        = pwm_q;
    level_d      = level_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    leds_d       = leds_q;
    step_pulse_d = 1'b0;

    if (run_c) begin
      pwm_d  = pwm_q + 1'b1;
      leds_d = pattern_c;
      if (mode_chg_c) begin
        mode_d  = mode_e'(mode);
        pre_d   = '0;
        ramp_d  = '0;
        pos_d   = '0;
        level_d = '0;
        phase_d = 1'b0;
        dir_d   = 1'b0;
      end else begin
        pre_d        = step_tick_c ? '0 : pre_q + 1'b1;
        step_pulse_d = step_tick_c;
        case (mode_q)
          M_MARQUEE: begin
            if (step_tick_c) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          end
          M_BLINK: begin
            if (step_tick_c) phase_d = ~phase_q;
          end
          M_BOUNCE: begin
            if (step_tick_c && (N_LEDS > 1)) begin
              if (!dir_q) begin
                pos_d = pos_q + 1'b1;
                if (pos_d == POS_LAST) dir_d = 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
                if (pos_d == '0) dir_d = 1'b0;
              end
            end
          end
          M_BREATHE: begin
            if (ramp_q == RAMP_LAST) begin
              ramp_d = '0;
              if (!dir_q) begin
                level_d = level_q + 1'b1;
                if (level_d == LVL_MAX) dir_d = 1'b1;
              end else begin
                level_d = level_q - 1'b1;
                if (level_d == '0) dir_d = 1'b0;
              end
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge pll_clk or posedge rst_sync) begin
    if (rst_sync) begin
      mode_q       <= M_MARQUEE;
      pre_q        <= '0;
      ramp_q       <= '0;
      pwm_q        <= '0;
      level_q      <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      phase_q      <= 1'b0;
      leds_q       <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pre_q        <= pre_d;
      ramp_q       <= ramp_d;
      pwm_q        <= pwm_d;
      level_q      <= level_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_pulse_q;

endmodule
